// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
//   state_t             : controller FSM state encoding
//   REG_ZERO            : hardwired-zero register index (never a hazard source)
//   DEFAULT_MUL_LATENCY : default EX occupancy of a multiply
//   DEFAULT_CNT_W       : default performance counter width
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MUL_BUSY = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned DEFAULT_MUL_LATENCY = 4;
  localparam int unsigned DEFAULT_CNT_W       = 16;

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter used for the performance debug counters.
//   clk   : clock
//   arst  : asynchronous active-high clear
//   inc   : increment request for this edge
//   count : current count, holds at all-ones once reached
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Hazard / stall controller for a 5-stage pipeline.
// Sequences PC, IF/ID, ID/EX and EX/MEM enables for load-use stalls, multi-cycle
// multiply freezes and taken-branch flushes; keeps saturating stall/flush counters.
//   clk, arst                        : clock, asynchronous active-high reset
//   ID_Rs, ID_Rt, ID_uses_rt         : source operands of the instruction in ID
//   EX_mem_read, EX_Rd               : load-in-EX detection
//   EX_mul_start, EX_branch_taken    : multiply entry / taken branch in EX
//   pc_write, IF_ID_write            : front-end advance enables
//   IF_ID_flush, ID_EX_bubble        : squash controls
//   ID_EX_write, EX_MEM_bubble       : ID/EX enable, NOP into EX/MEM while frozen
//   mul_busy                         : multiply occupying EX
//   stall_cycles, flush_events       : performance counters
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_uses_rt,
  input  logic             EX_mem_read,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_mul_start,
  input  logic             EX_branch_taken,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_bubble,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned BUSY_W = $clog2(MUL_LATENCY);
  // Entry cycle happens in RUN and the exit edge sees zero, hence the -2.
  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(MUL_LATENCY - 2);

  state_t            state_q, state_d;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              load_use;
  logic              stall_inc;
  logic              flush_inc;

  assign load_use = EX_mem_read && (EX_Rd != REG_ZERO) &&
                    ((ID_Rs == EX_Rd) || (ID_uses_rt && (ID_Rt == EX_Rd)));

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= INIT;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    unique case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        // A taken branch squashes the would-be multiply in EX.
        if (!EX_branch_taken && EX_mul_start) begin
          state_d    = MUL_BUSY;
          busy_cnt_d = BUSY_LOAD;
        end
      end
      MUL_BUSY: begin
        if (busy_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          busy_cnt_d = busy_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d    = INIT;
        busy_cnt_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    pc_write      = 1'b0;
    IF_ID_write   = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b0;
    ID_EX_bubble  = 1'b0;
    EX_MEM_bubble = 1'b0;
    mul_busy      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (EX_branch_taken) begin
          pc_write     = 1'b1;
          IF_ID_write  = 1'b1;
          IF_ID_flush  = 1'b1;
          ID_EX_write  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else if (EX_mul_start) begin
          EX_MEM_bubble = 1'b1;
          mul_busy      = 1'b1;
        end else if (load_use) begin
          ID_EX_write  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else begin
          pc_write    = 1'b1;
          IF_ID_write = 1'b1;
          ID_EX_write = 1'b1;
        end
      end
      MUL_BUSY: begin
        EX_MEM_bubble = 1'b1;
        mul_busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_inc = !pc_write && (state_q != INIT);
  assign flush_inc = (state_q == RUN) && EX_branch_taken;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .arst (arst),
    .inc  (stall_inc),
    .count(stall_cycles)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .arst (arst),
    .inc  (flush_inc),
    .count(flush_events)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        arst;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rd;
  logic        ID_uses_rt, EX_mem_read, EX_mul_start, EX_branch_taken;

  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_write;
  logic        ID_EX_bubble, EX_MEM_bubble, mul_busy;
  logic [15:0] stall_cycles, flush_events;

  logic        s_pc_write, s_IF_ID_write, s_IF_ID_flush, s_ID_EX_write;
  logic        s_ID_EX_bubble, s_EX_MEM_bubble, s_mul_busy;
  logic [1:0]  s_stall_cycles, s_flush_events;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MUL_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .arst(arst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_rt(ID_uses_rt),
    .EX_mem_read(EX_mem_read), .EX_Rd(EX_Rd), .EX_mul_start(EX_mul_start),
    .EX_branch_taken(EX_branch_taken), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble),
    .EX_MEM_bubble(EX_MEM_bubble), .mul_busy(mul_busy), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  hazard_stall_controller #(.MUL_LATENCY(4), .CNT_W(2)) dut_sat (
    .clk(clk), .arst(arst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_rt(ID_uses_rt),
    .EX_mem_read(EX_mem_read), .EX_Rd(EX_Rd), .EX_mul_start(EX_mul_start),
    .EX_branch_taken(EX_branch_taken), .pc_write(s_pc_write), .IF_ID_write(s_IF_ID_write),
    .IF_ID_flush(s_IF_ID_flush), .ID_EX_write(s_ID_EX_write), .ID_EX_bubble(s_ID_EX_bubble),
    .EX_MEM_bubble(s_EX_MEM_bubble), .mul_busy(s_mul_busy), .stall_cycles(s_stall_cycles),
    .flush_events(s_flush_events)
  );

  // Control vector: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
  //                  EX_MEM_bubble, mul_busy}
  localparam logic [6:0] C_INIT = 7'b0000000;
  localparam logic [6:0] C_RUN  = 7'b1101000;
  localparam logic [6:0] C_LU   = 7'b0001100;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_MUL  = 7'b0000011;

  localparam int SEL_CTRL = 0, SEL_STALL = 1, SEL_FLUSH = 2, SEL_SFLUSH = 3, SEL_SSTALL = 4;

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t  sb_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.sel = sel;
    c.exp = exp;
    sb_q.push_back(c);
    name_q.push_back(name);
  endtask

  task automatic exp_ctrl(input string name, input logic [6:0] v);
    push(name, SEL_CTRL, {25'd0, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_uses_rt = 1'b0; EX_mem_read = 1'b0;
    EX_Rd = 5'd0; EX_mul_start = 1'b0; EX_branch_taken = 1'b0;
  endtask

  // Monitor
  chk_t        m_c;
  string       m_n;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      m_c = sb_q.pop_front();
      m_n = name_q.pop_front();
      case (m_c.sel)
        SEL_CTRL:   m_act = {25'd0, pc_write, IF_ID_write, IF_ID_flush, ID_EX_write,
                             ID_EX_bubble, EX_MEM_bubble, mul_busy};
        SEL_STALL:  m_act = {16'd0, stall_cycles};
        SEL_FLUSH:  m_act = {16'd0, flush_events};
        SEL_SFLUSH: m_act = {30'd0, s_flush_events};
        default:    m_act = {30'd0, s_stall_cycles};
      endcase
      checks++;
      if (m_act !== m_c.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", m_n, m_act, m_c.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_in();
    arst = 1'b1;
    #2;
    exp_ctrl("reset_ctrl", C_INIT);
    push("reset_stall", SEL_STALL, 0);
    push("reset_flush", SEL_FLUSH, 0);
    step();
    arst = 1'b0;
    exp_ctrl("init_ctrl", C_INIT);
    push("init_stall", SEL_STALL, 0);
    step();
    exp_ctrl("run_after_init", C_RUN);

    // Load-use on Rs
    step();
    EX_mem_read = 1'b1; EX_Rd = 5'd8; ID_Rs = 5'd8;
    exp_ctrl("lu_rs_ctrl", C_LU);
    step();
    clear_in();
    exp_ctrl("lu_rs_release", C_RUN);
    push("lu_rs_stall", SEL_STALL, 1);

    // Load to $0 never stalls
    step();
    EX_mem_read = 1'b1; EX_Rd = 5'd0; ID_Rs = 5'd0;
    exp_ctrl("lu_r0_ctrl", C_RUN);
    step();
    clear_in();
    push("lu_r0_stall", SEL_STALL, 1);

    // Rt gating
    step();
    EX_mem_read = 1'b1; EX_Rd = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd3; ID_uses_rt = 1'b0;
    exp_ctrl("rt_unused_ctrl", C_RUN);
    step();
    ID_uses_rt = 1'b1;
    exp_ctrl("rt_used_ctrl", C_LU);
    push("rt_used_stall_before", SEL_STALL, 1);
    step();
    clear_in();
    exp_ctrl("rt_release", C_RUN);
    push("rt_stall", SEL_STALL, 2);

    // Multiply freeze, branch in cycle 2 ignored
    step();
    EX_mul_start = 1'b1;
    exp_ctrl("mul_c1", C_MUL);
    step();
    EX_mul_start = 1'b0; EX_branch_taken = 1'b1;
    exp_ctrl("mul_c2", C_MUL);
    push("mul_c2_stall", SEL_STALL, 3);
    step();
    EX_branch_taken = 1'b0;
    exp_ctrl("mul_c3", C_MUL);
    step();
    exp_ctrl("mul_c4", C_MUL);
    push("mul_c4_stall", SEL_STALL, 5);
    step();
    exp_ctrl("mul_done", C_RUN);
    push("mul_stall", SEL_STALL, 6);
    push("mul_flush", SEL_FLUSH, 0);

    // Branch beats load-use
    step();
    EX_branch_taken = 1'b1; EX_mem_read = 1'b1; EX_Rd = 5'd8; ID_Rs = 5'd8;
    exp_ctrl("br_prio_ctrl", C_BR);
    step();
    clear_in();
    exp_ctrl("br_after", C_RUN);
    push("br_flush", SEL_FLUSH, 1);
    push("br_stall", SEL_STALL, 6);
    push("sat_flush_1", SEL_SFLUSH, 1);
    push("sat_stall_sat", SEL_SSTALL, 3);

    // Five more flushes: CNT_W=2 copy saturates
    for (int i = 0; i < 5; i++) begin
      step();
      EX_branch_taken = 1'b1;
      exp_ctrl("br_burst", C_BR);
    end
    step();
    clear_in();
    push("flush_count", SEL_FLUSH, 6);
    push("sat_flush_hold", SEL_SFLUSH, 3);

    // Back-to-back multiplies: second starts only after RUN re-entered
    step();
    EX_mul_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_ctrl("b2b_mul", C_MUL);
      if (i < 4) step();
    end
    step();
    EX_mul_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_ctrl("b2b_busy", C_MUL);
      step();
    end
    exp_ctrl("b2b_done", C_RUN);
    push("b2b_stall", SEL_STALL, 14);

    // Reset during MUL_BUSY cycle 2
    step();
    EX_mul_start = 1'b1;
    exp_ctrl("rst_mul_c1", C_MUL);
    step();
    EX_mul_start = 1'b0;
    #1;
    arst = 1'b1;
    exp_ctrl("rst_mid_mul", C_INIT);
    push("rst_mid_stall", SEL_STALL, 0);
    push("rst_mid_flush", SEL_FLUSH, 0);
    push("rst_mid_sflush", SEL_SFLUSH, 0);
    step();
    arst = 1'b0;
    exp_ctrl("rst_init", C_INIT);
    step();
    exp_ctrl("rst_run", C_RUN);
    push("rst_run_stall", SEL_STALL, 0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
